// File: rtl/double_crack.sv
// ARC4 key search: copies a length-prefixed ciphertext, then runs two ARC4 crack engines on even/odd keys.
// Latency: L+5 cycles copy, ~(512+L+1) cycles per key pair, L+3 cycles plaintext copy-out.
// Backpressure: en is only taken while rdy=1; a start request while busy is dropped, not queued.

// Crack engine: tries keys i_key_start, +i_key_step, ... up to KEY_LAST against its private ct copy.
// One key costs 256 init + 256 KSA + L PRGA + 1 check cycles; the cost is independent of the data.
// i_en is only honoured while idle; i_kill returns the engine to idle on the next edge.
module double_crack_engine #(
    parameter logic [23:0] KEY_LAST = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_kill,
    input  logic [23:0] i_key_start,
    input  logic [23:0] i_key_step,
    input  logic        i_ct_we,
    input  logic [7:0]  i_ct_addr,
    input  logic [7:0]  i_ct_wdat,
    input  logic [7:0]  i_pt_addr,
    output logic        o_rdy,
    output logic [23:0] o_key,
    output logic        o_key_valid,
    output logic [7:0]  o_pt_rdat
);
    typedef enum logic [1:0] {E_IDLE, E_INIT, E_KSA, E_PRGA} est_t;

    logic [7:0]  ct  [256];
    logic [7:0]  pt  [256];
    logic [7:0]  r_s [256];
    est_t        r_st;
    logic [23:0] r_key, r_step;
    logic [7:0]  r_i, r_j;
    logic [1:0]  r_m;
    logic [8:0]  r_k;
    logic        r_ok, r_rdy, r_kv;
    logic [7:0]  r_pt_rdat;

    logic [7:0]  w_kb, w_si, w_j_ksa, w_i1, w_si1, w_j1, w_sj1, w_t, w_pad, w_p;
    logic        w_end, w_printable;
    logic [24:0] w_next;

    // Key bytes are consumed big-endian, cycling every three KSA steps.
    assign w_kb    = (r_m == 2'd0) ? r_key[23:16] : (r_m == 2'd1) ? r_key[15:8] : r_key[7:0];
    assign w_si    = r_s[r_i];
    assign w_j_ksa = r_j + w_si + w_kb;
    // PRGA step; the pad lookup must see the post-swap contents of S.
    assign w_i1    = r_i + 8'd1;
    assign w_si1   = r_s[w_i1];
    assign w_j1    = r_j + w_si1;
    assign w_sj1   = r_s[w_j1];
    assign w_t     = w_si1 + w_sj1;
    assign w_pad   = (w_t == w_i1) ? w_sj1 : (w_t == w_j1) ? w_si1 : r_s[w_t];
    assign w_p     = ct[r_k[7:0]] ^ w_pad;
    assign w_printable = (w_p >= 8'h20) && (w_p <= 8'h7E);
    assign w_end   = r_k > {1'b0, ct[0]};
    assign w_next  = {1'b0, r_key} + {1'b0, r_step};

    assign o_rdy       = r_rdy;
    assign o_key       = r_key;
    assign o_key_valid = r_kv;
    assign o_pt_rdat   = r_pt_rdat;

    // Per-key control: init S, run KSA, decrypt all L bytes, then accept or advance the key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= E_IDLE; r_key <= '0; r_step <= '0; r_i <= '0; r_j <= '0;
            r_m <= '0; r_k <= '0; r_ok <= 1'b0; r_rdy <= 1'b1; r_kv <= 1'b0;
        end else if (i_kill) begin
            r_st <= E_IDLE; r_rdy <= 1'b1; r_kv <= 1'b0;
        end else begin
            case (r_st)
                E_IDLE: if (i_en) begin
                    r_key <= i_key_start; r_step <= i_key_step; r_rdy <= 1'b0;
                    r_kv <= 1'b0; r_i <= '0; r_st <= E_INIT;
                end
                E_INIT: begin
                    r_i <= w_i1;
                    if (r_i == 8'hFF) begin r_j <= '0; r_m <= '0; r_st <= E_KSA; end
                end
                E_KSA: begin
                    r_i <= w_i1; r_j <= w_j_ksa;
                    r_m <= (r_m == 2'd2) ? 2'd0 : r_m + 2'd1;
                    if (r_i == 8'hFF) begin r_j <= '0; r_k <= 9'd1; r_ok <= 1'b1; r_st <= E_PRGA; end
                end
                E_PRGA: begin
                    if (w_end) begin
                        if (r_ok) begin
                            r_kv <= 1'b1; r_rdy <= 1'b1; r_st <= E_IDLE;
                        end else if (w_next > {1'b0, KEY_LAST}) begin
                            r_kv <= 1'b0; r_rdy <= 1'b1; r_st <= E_IDLE;
                        end else begin
                            r_key <= w_next[23:0]; r_i <= '0; r_st <= E_INIT;
                        end
                    end else begin
                        r_i <= w_i1; r_j <= w_j1; r_k <= r_k + 9'd1;
                        if (!w_printable) r_ok <= 1'b0;
                    end
                end
                default: r_st <= E_IDLE;
            endcase
        end
    end

    // Storage: ct fill port, registered pt read port, S permutation and plaintext writes.
    always_ff @(posedge clk) begin
        if (i_ct_we) ct[i_ct_addr] <= i_ct_wdat;
        r_pt_rdat <= pt[i_pt_addr];
        case (r_st)
            E_INIT: begin r_s[r_i] <= r_i; pt[0] <= ct[0]; end
            E_KSA:  begin r_s[r_i] <= r_s[w_j_ksa]; r_s[w_j_ksa] <= w_si; end
            E_PRGA: if (!w_end) begin
                r_s[w_i1] <= w_sj1; r_s[w_j1] <= w_si1; pt[r_k[7:0]] <= w_p;
            end
            default: ;
        endcase
    end
endmodule

module double_crack #(
    parameter logic [23:0] KEY_LAST = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata
);
    typedef enum logic [2:0] {S_IDLE, S_COPY, S_START, S_SEARCH, S_COPYPT, S_DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_ph;
    logic        r_rdy, r_key_valid, r_rd_vld, r_a_done, r_b_done, r_win, r_kill, r_pv;
    logic [23:0] r_key, r_win_key;
    logic [7:0]  r_ct_addr, r_rd_addr, r_len, r_pt_addr, r_pw_addr;
    logic [7:0]  pt [256];

    logic        w_eng_en, w_a_rdy, w_b_rdy, w_a_kv, w_b_kv, w_a_ret, w_b_ret;
    logic [23:0] w_a_key, w_b_key;
    logic [7:0]  w_a_pt, w_b_pt, w_pt_rd;

    assign rdy       = r_rdy;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign ct_addr   = r_ct_addr;

    assign w_eng_en = (r_state == S_START);
    assign w_a_ret  = (r_state == S_SEARCH) && w_a_rdy && !r_a_done;
    assign w_b_ret  = (r_state == S_SEARCH) && w_b_rdy && !r_b_done;
    assign w_pt_rd  = r_win ? w_b_pt : w_a_pt;

    double_crack_engine #(.KEY_LAST(KEY_LAST)) u_eng_a (
        .clk(clk), .rst_n(rst_n), .i_en(w_eng_en), .i_kill(r_kill),
        .i_key_start(24'd0), .i_key_step(24'd2),
        .i_ct_we(r_rd_vld), .i_ct_addr(r_rd_addr), .i_ct_wdat(ct_rddata),
        .i_pt_addr(r_pt_addr), .o_rdy(w_a_rdy), .o_key(w_a_key),
        .o_key_valid(w_a_kv), .o_pt_rdat(w_a_pt));

    double_crack_engine #(.KEY_LAST(KEY_LAST)) u_eng_b (
        .clk(clk), .rst_n(rst_n), .i_en(w_eng_en), .i_kill(r_kill),
        .i_key_start(24'd1), .i_key_step(24'd2),
        .i_ct_we(r_rd_vld), .i_ct_addr(r_rd_addr), .i_ct_wdat(ct_rddata),
        .i_pt_addr(r_pt_addr), .o_rdy(w_b_rdy), .o_key(w_b_key),
        .o_key_valid(w_b_kv), .o_pt_rdat(w_b_pt));

    // Top sequencer: accept start, copy CT, launch engines, arbitrate winner, copy plaintext out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE; r_ph <= '0; r_rdy <= 1'b1; r_key <= '0; r_key_valid <= 1'b0;
            r_ct_addr <= '0; r_rd_vld <= 1'b0; r_rd_addr <= '0; r_len <= '0;
            r_a_done <= 1'b0; r_b_done <= 1'b0; r_win <= 1'b0; r_win_key <= '0;
            r_kill <= 1'b0; r_pv <= 1'b0; r_pt_addr <= '0; r_pw_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (en) begin
                        r_rdy <= 1'b0; r_key_valid <= 1'b0; r_ct_addr <= '0;
                        r_ph <= '0; r_state <= S_COPY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_COPY: begin
                    if (r_rd_vld && r_rd_addr == 8'd0) r_len <= ct_rddata;
                    case (r_ph)
                        // Address 0 is on the bus; its data (the length) arrives next cycle.
                        2'd0: begin r_rd_vld <= 1'b1; r_rd_addr <= '0; r_ph <= 2'd1; end
                        2'd1: begin
                            r_rd_vld <= 1'b0;
                            if (ct_rddata == 8'd0) r_ph <= 2'd3;
                            else begin r_ct_addr <= 8'd1; r_ph <= 2'd2; end
                        end
                        2'd2: begin
                            r_rd_vld <= 1'b1; r_rd_addr <= r_ct_addr;
                            if (r_ct_addr == r_len) r_ph <= 2'd3;
                            else r_ct_addr <= r_ct_addr + 8'd1;
                        end
                        default: begin
                            r_rd_vld <= 1'b0;
                            if (!r_rd_vld) r_state <= S_START;
                        end
                    endcase
                end
                S_START: begin
                    r_a_done <= 1'b0; r_b_done <= 1'b0; r_state <= S_SEARCH;
                end
                S_SEARCH: begin
                    // Engine A checks first so an even key wins a same-cycle tie.
                    if (w_a_ret && w_a_kv) begin
                        r_win <= 1'b0; r_win_key <= w_a_key; r_kill <= 1'b1;
                        r_pt_addr <= '0; r_ph <= '0; r_state <= S_COPYPT;
                    end else if (w_b_ret && w_b_kv) begin
                        r_win <= 1'b1; r_win_key <= w_b_key; r_kill <= 1'b1;
                        r_pt_addr <= '0; r_ph <= '0; r_state <= S_COPYPT;
                    end else begin
                        if (w_a_ret) r_a_done <= 1'b1;
                        if (w_b_ret) r_b_done <= 1'b1;
                        if ((r_a_done || w_a_ret) && (r_b_done || w_b_ret)) begin
                            r_key <= '0; r_key_valid <= 1'b0; r_rdy <= 1'b1; r_state <= S_DONE;
                        end
                    end
                end
                S_COPYPT: begin
                    r_kill <= 1'b0;
                    if (r_ph == 2'd0) begin
                        r_pv <= 1'b1; r_pw_addr <= r_pt_addr;
                        if (r_pt_addr == r_len) r_ph <= 2'd3;
                        else r_pt_addr <= r_pt_addr + 8'd1;
                    end else begin
                        r_pv <= 1'b0;
                        if (!r_pv) begin
                            r_key <= r_win_key; r_key_valid <= 1'b1; r_rdy <= 1'b1; r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Local plaintext RAM, filled from the winning engine one cycle after each read.
    always_ff @(posedge clk) begin
        if (r_pv) pt[r_pw_addr] <= w_pt_rd;
    end
endmodule

// File: tb/tb_double_crack.sv
`timescale 1ns/1ps
module tb_double_crack;
    localparam logic [23:0] KL = 24'h00003F;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic        rdy, key_valid;
    logic [23:0] key;
    logic [7:0]  ct_addr, ct_rddata;

    logic [7:0]  mem    [256];
    logic [7:0]  ks     [256];
    logic [7:0]  exp_pt [256];

    typedef struct packed { logic [23:0] key; logic kv; } exp_t;
    exp_t sb_q[$];
    int   n_vec = 0, n_miss = 0;

    double_crack #(.KEY_LAST(KL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata));

    always #5 clk = ~clk;

    // Synchronous-read CT memory.
    always @(posedge clk) ct_rddata <= mem[ct_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference ARC4 keystream bytes 1..n for a 24-bit key (big-endian key bytes).
    function automatic void gen_ks(input logic [23:0] k, input int n);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, u;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = j + s[a] + kb[a % 3];
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 8'd0; j = 8'd0;
        for (int b = 1; b <= n; b++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            u = s[i] + s[j];
            ks[b] = s[u];
        end
    endfunction

    task automatic load_ct(input logic [23:0] k, input int len);
        logic [7:0] p;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        gen_ks(k, len);
        mem[0] = 8'(len);
        for (int b = 1; b <= len; b++) begin
            p = 8'(8'h20 + $urandom_range(0, 94));
            mem[b] = p ^ ks[b];
        end
    endtask

    // Model: the lowest key <= KL that decrypts to printable text; push expectation, pulse en.
    task automatic launch(input int len);
        logic found, ok;
        logic [23:0] fk;
        logic [7:0] p;
        exp_t e;
        found = 1'b0; fk = 24'd0;
        for (int kk = 0; kk <= int'(KL) && !found; kk++) begin
            gen_ks(24'(kk), len);
            ok = 1'b1;
            for (int b = 1; b <= len; b++) begin
                p = mem[b] ^ ks[b];
                if (p < 8'h20 || p > 8'h7E) ok = 1'b0;
            end
            if (ok) begin
                found = 1'b1; fk = 24'(kk);
                for (int b = 1; b <= len; b++) exp_pt[b] = mem[b] ^ ks[b];
            end
        end
        exp_pt[0] = 8'(len);
        e.key = found ? fk : 24'd0;
        e.kv  = found;
        sb_q.push_back(e);
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        chk("rdy_low_after_start", 32'(rdy), 32'd0);
        chk("kv_clear_on_start", 32'(key_valid), 32'd0);
    endtask

    task automatic finish_run(input int len);
        logic [7:0] prev, amax;
        int bad, cyc;
        exp_t e;
        prev = ct_addr; amax = ct_addr; bad = 0; cyc = 0;
        while (!rdy && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (ct_addr != prev && ct_addr != prev + 8'd1) bad++;
            if (ct_addr > amax) amax = ct_addr;
            if (cyc == 50 && !rdy) chk("kv_low_during_run", 32'(key_valid), 32'd0);
            prev = ct_addr;
        end
        chk("run_completes", 32'(rdy), 32'd1);
        chk("ct_addr_max", 32'(amax), 32'(len));
        chk("ct_addr_steps", 32'(bad), 32'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("key", 32'(key), 32'(e.key));
            chk("key_valid", 32'(key_valid), 32'(e.kv));
            if (e.kv)
                for (int b = 0; b <= len; b++)
                    chk($sformatf("pt[%0d]", b), 32'(dut.pt[b]), 32'(exp_pt[b]));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_kv", 32'(key_valid), 32'd0);
        chk("reset_key", 32'(key), 32'd0);
        chk("reset_ct_addr", 32'(ct_addr), 32'd0);

        // Even key, L=3, then back-to-back odd key.
        load_ct(24'h000018, 3); launch(3); finish_run(3);
        load_ct(24'h000019, 5); launch(5); finish_run(5);

        // Mid-search: ignored en, then asynchronous reset abandons the run.
        load_ct(24'h000030, 6); launch(6);
        repeat (300) @(negedge clk);
        chk("busy_mid_search", 32'(rdy), 32'd0);
        en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_ignored_rdy", 32'(rdy), 32'd0);
        chk("en_ignored_ct_addr", 32'(ct_addr), 32'd6);
        #1 rst_n = 1'b0;
        #0.005;
        chk("abort_rdy", 32'(rdy), 32'd1);
        chk("abort_kv", 32'(key_valid), 32'd0);
        chk("abort_key", 32'(key), 32'd0);
        #0.005 rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("idle_after_abort", 32'(rdy), 32'd1);

        // Fresh run after abort.
        load_ct(24'h00000A, 8); launch(8); finish_run(8);
        // Key beyond KEY_LAST: exhaustion.
        load_ct(24'h000050, 12); launch(12); finish_run(12);
        // Back-to-back after a not-found run.
        load_ct(24'h00002B, 4); launch(4); finish_run(4);
        // Zero-length ciphertext: only the length byte is copied.
        load_ct(24'h000007, 0); launch(0); finish_run(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
